// File: rtl/io_pad_ctrl_pkg.sv
// Shared pad-mode encoding, the idle-level rule and the per-mode pad driver
// used by the pad controller and its per-pin input filter.
package io_pad_ctrl_pkg;

    typedef enum logic [1:0] {
        PAD_FLOAT     = 2'd0,
        PAD_IDLE_HIGH = 2'd1,
        PAD_IDLE_LOW  = 2'd2,
        PAD_OPEN_DRN  = 2'd3
    } pad_mode_e;

    typedef struct packed {
        logic oe;
        logic out;
    } pad_drv_t;

    localparam int unsigned FILT_CNT_W = 8;

    // Level a pin rests at when nobody drives it; also the reset value of its input path.
    function automatic logic idle_level(input pad_mode_e mode);
        return (mode == PAD_IDLE_HIGH) || (mode == PAD_OPEN_DRN);
    endfunction

    function automatic pad_drv_t pad_drive(input pad_mode_e mode, input logic dir,
                                           input logic dout);
        pad_drv_t drv;
        drv = '0;
        unique case (mode)
            PAD_FLOAT: begin
                drv.oe  = dir;
                drv.out = dout;
            end
            PAD_IDLE_HIGH: begin
                drv.oe  = 1'b1;
                drv.out = dir ? dout : 1'b1;
            end
            PAD_IDLE_LOW: begin
                drv.oe  = 1'b1;
                drv.out = dir ? dout : 1'b0;
            end
            PAD_OPEN_DRN: begin
                drv.oe  = dir & ~dout;
                drv.out = 1'b0;
            end
            default: drv = '0;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/io_pin_filt.sv
// One pin's input path: SYNC_STAGES-deep synchroniser followed by an optional
// glitch filter that only passes a level held for FILT_CYCLES consecutive cycles.
module io_pin_filt
    import io_pad_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 0,
    parameter logic        IDLE        = 1'b0
) (
    input  logic clk_cog,
    input  logic res,
    input  logic raw_i,
    output logic pin_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk_cog) begin
        if (res) begin
            sync_q <= {SYNC_STAGES{IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    if (FILT_CYCLES == 0) begin : g_bypass
        assign pin_o = sync_q[SYNC_STAGES-1];
    end else begin : g_filt
        localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_CYCLES - 1);

        logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
        logic                  pin_q, pin_d;

        // NOTE: defaults first so no path through this block leaves a latch behind.
        always_comb begin
            cnt_d = '0;
            pin_d = pin_q;
            if (sync_q[SYNC_STAGES-1] != pin_q) begin
                if (cnt_q == CNT_LAST) begin
                    pin_d = ~pin_q;
                end else begin
                    cnt_d = cnt_q + FILT_CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk_cog) begin
            if (res) begin
                cnt_q <= '0;
                pin_q <= IDLE;
            end else begin
                cnt_q <= cnt_d;
                pin_q <= pin_d;
            end
        end

        assign pin_o = pin_q;
    end

endmodule

// File: rtl/io_pad_ctrl.sv
// Pad controller between the core pins and the FPGA pads: per-pin pad-mode muxes,
// synchronised/filtered inputs and the reset-stretch counter that drives nres.
module io_pad_ctrl
    import io_pad_ctrl_pkg::*;
#(
    parameter int unsigned            NPINS       = 32,
    parameter logic [2*NPINS-1:0]     PAD_MODE    = (2*NPINS)'(64'h05 << 56),
    parameter logic [NPINS-1:0]       AUX_MASK    = NPINS'(32'h2000_0000),
    parameter int unsigned            SYNC_STAGES = 2,
    parameter int unsigned            FILT_CYCLES = 0,
    parameter int unsigned            RST_CYCLES  = 1024
) (
    input  logic             clk_cog,
    input  logic             res,
    input  logic             cfg_rst,
    input  logic [NPINS-1:0] pin_out,
    input  logic [NPINS-1:0] pin_dir,
    input  logic [NPINS-1:0] pad_in,
    input  logic [NPINS-1:0] aux_in,
    output logic [NPINS-1:0] pad_out,
    output logic [NPINS-1:0] pad_oe,
    output logic [NPINS-1:0] pin_in,
    output logic             nres
);

    localparam int unsigned RCNT_W = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(RST_CYCLES);

    logic [NPINS-1:0] raw;

    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        localparam pad_mode_e MODE = pad_mode_e'(PAD_MODE[2*i +: 2]);

        pad_drv_t drv;

        // Output enables are forced off while the chip is in hard reset, never by cfg_rst.
        assign drv        = pad_drive(MODE, pin_dir[i], pin_out[i]);
        assign pad_oe[i]  = drv.oe & ~res;
        assign pad_out[i] = drv.out;

        assign raw[i] = pad_in[i] & (aux_in[i] | ~AUX_MASK[i]);

        io_pin_filt #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .IDLE        (idle_level(MODE))
        ) u_filt (
            .clk_cog (clk_cog),
            .res     (res),
            .raw_i   (raw[i]),
            .pin_o   (pin_in[i])
        );
    end

    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              nres_q, nres_d;
    logic              stretch_rst;

    assign stretch_rst = res | cfg_rst;

    always_comb begin
        rcnt_d = rcnt_q;
        if (rcnt_q != RCNT_MAX) begin
            rcnt_d = rcnt_q + RCNT_W'(1);
        end
        nres_d = (rcnt_q == RCNT_MAX);
    end

    always_ff @(posedge clk_cog) begin
        if (stretch_rst) begin
            rcnt_q <= '0;
            nres_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            nres_q <= nres_d;
        end
    end

    assign nres = nres_q;

endmodule
